alu_logic_sequencer: RTL and testbench

Initiator side of the ALU logic-unit interface. Accepts logic-operation requests (4-bit opcode, two WIDTH-bit operands) over a valid/ready handshake, drives the logic unit's `operation`/`lhs_in`/`rhs_in` inputs and generates its `alu_clk` strobe. After the unit has registered its result, the sequencer captures `out` and returns it with zero/negative flags over a second valid/ready handshake. Sits between the instruction decode/control path and the logic unit.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_flags.sv | 13 +
 rtl/alu_logic_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_logic_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic-unit interface: the 16 logic opcodes and the sequencer state type.
package alu_pkg;

    // Opcode bit {lhs_bit, rhs_bit} is the truth-table output for that operand bit pair.
    localparam logic [3:0] ALU_ZERO         = 4'h0;
    localparam logic [3:0] ALU_NOR          = 4'h1;
    localparam logic [3:0] ALU_NLHS_AND_RHS = 4'h2;
    localparam logic [3:0] ALU_NOT_LHS      = 4'h3;
    localparam logic [3:0] ALU_LHS_AND_NRHS = 4'h4;
    localparam logic [3:0] ALU_NOT_RHS      = 4'h5;
    localparam logic [3:0] ALU_XOR          = 4'h6;
    localparam logic [3:0] ALU_NAND         = 4'h7;
    localparam logic [3:0] ALU_AND          = 4'h8;
    localparam logic [3:0] ALU_XNOR         = 4'h9;
    localparam logic [3:0] ALU_RHS          = 4'hA;
    localparam logic [3:0] ALU_NLHS_OR_RHS  = 4'hB;
    localparam logic [3:0] ALU_LHS          = 4'hC;
    localparam logic [3:0] ALU_LHS_OR_NRHS  = 4'hD;
    localparam logic [3:0] ALU_OR           = 4'hE;
    localparam logic [3:0] ALU_ONES         = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } seq_state_t;

endpackage

// File: rtl/alu_flags.sv
// Zero/negative flag generation for a WIDTH-bit result; shared by the logic and arithmetic paths.
module alu_flags #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero,
    output logic             o_neg
);

    assign o_zero = (i_value == '0);
    assign o_neg  = i_value[WIDTH-1];

endmodule

// File: rtl/alu_logic_sequencer.sv
// Initiator for the ALU logic unit: takes a request, holds operands for SETTLE_CYCLES, emits one
// alu_clk strobe, captures the unit's registered result and returns it with zero/negative flags.
module alu_logic_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_lhs,
    input  logic [WIDTH-1:0] req_rhs,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic [3:0]       alu_operation,
    output logic [WIDTH-1:0] alu_lhs,
    output logic [WIDTH-1:0] alu_rhs,
    output logic             alu_clk,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alu_clk;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_lhs;
    logic [WIDTH-1:0] r_alu_rhs;
    logic [WIDTH-1:0] r_rsp_data;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic             w_accept;

    assign w_accept = req_valid && w_req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = SETUP;
            SETUP:   if (r_cnt == '0) w_next_state = STROBE;
            STROBE:  w_next_state = CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = req_valid ? SETUP : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A new request is taken in the same cycle the current response is consumed.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: w_req_ready = 1'b1;
            RESP: begin
                w_rsp_valid = 1'b1;
                w_req_ready = rsp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_alu_clk  <= 1'b0;
            r_alu_op   <= '0;
            r_alu_lhs  <= '0;
            r_alu_rhs  <= '0;
            r_rsp_data <= '0;
        end else begin
            // Strobe is registered from the next state so the unit sees a glitch-free clock.
            r_alu_clk <= (w_next_state == STROBE);
            if (w_accept) begin
                r_cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                r_alu_op  <= req_op;
                r_alu_lhs <= req_lhs;
                r_alu_rhs <= req_rhs;
            end else if ((r_state == SETUP) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (r_state == CAPTURE) begin
                r_rsp_data <= alu_result;
            end
        end
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_alu_flags (
        .i_value (r_rsp_data),
        .o_zero  (rsp_zero),
        .o_neg   (rsp_neg)
    );

    assign req_ready     = w_req_ready;
    assign rsp_valid     = w_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign alu_operation = r_alu_op;
    assign alu_lhs       = r_alu_lhs;
    assign alu_rhs       = r_alu_rhs;
    assign alu_clk       = r_alu_clk;

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Directed bench: two sequencers (SETTLE_CYCLES 1 and 3), each driving a truth-table logic unit model.
module tb_alu_logic_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       reset;

    logic       req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_zero_a, rsp_neg_a, alu_clk_a;
    logic [3:0] req_op_a, alu_op_a;
    logic [7:0] req_lhs_a, req_rhs_a, rsp_data_a, alu_lhs_a, alu_rhs_a, unit_out_a;

    logic       req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_zero_b, rsp_neg_b, alu_clk_b;
    logic [3:0] req_op_b, alu_op_b;
    logic [7:0] req_lhs_b, req_rhs_b, rsp_data_b, alu_lhs_b, alu_rhs_b, unit_out_b;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  pulses_a = 0;
    int  pulses_b = 0;
    time prev_pulse_t = 0;
    time last_pulse_t = 0;

    alu_logic_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid_a),
        .req_ready     (req_ready_a),
        .req_op        (req_op_a),
        .req_lhs       (req_lhs_a),
        .req_rhs       (req_rhs_a),
        .rsp_valid     (rsp_valid_a),
        .rsp_ready     (rsp_ready_a),
        .rsp_data      (rsp_data_a),
        .rsp_zero      (rsp_zero_a),
        .rsp_neg       (rsp_neg_a),
        .alu_operation (alu_op_a),
        .alu_lhs       (alu_lhs_a),
        .alu_rhs       (alu_rhs_a),
        .alu_clk       (alu_clk_a),
        .alu_result    (unit_out_a)
    );

    alu_logic_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid_b),
        .req_ready     (req_ready_b),
        .req_op        (req_op_b),
        .req_lhs       (req_lhs_b),
        .req_rhs       (req_rhs_b),
        .rsp_valid     (rsp_valid_b),
        .rsp_ready     (rsp_ready_b),
        .rsp_data      (rsp_data_b),
        .rsp_zero      (rsp_zero_b),
        .rsp_neg       (rsp_neg_b),
        .alu_operation (alu_op_b),
        .alu_lhs       (alu_lhs_b),
        .alu_rhs       (alu_rhs_b),
        .alu_clk       (alu_clk_b),
        .alu_result    (unit_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic unit model: each result bit is the opcode bit selected by {lhs_bit, rhs_bit}.
    function automatic logic [7:0] unit_eval(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = op[{a[i], b[i]}];
        return y;
    endfunction

    // Independent reference: the named bitwise operation for each opcode.
    function automatic logic [7:0] ref_logic(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_ZERO:         return 8'h00;
            ALU_NOR:          return ~(a | b);
            ALU_NLHS_AND_RHS: return ~a & b;
            ALU_NOT_LHS:      return ~a;
            ALU_LHS_AND_NRHS: return a & ~b;
            ALU_NOT_RHS:      return ~b;
            ALU_XOR:          return a ^ b;
            ALU_NAND:         return ~(a & b);
            ALU_AND:          return a & b;
            ALU_XNOR:         return ~(a ^ b);
            ALU_RHS:          return b;
            ALU_NLHS_OR_RHS:  return ~a | b;
            ALU_LHS:          return a;
            ALU_LHS_OR_NRHS:  return a | ~b;
            ALU_OR:           return a | b;
            default:          return 8'hFF;
        endcase
    endfunction

    initial unit_out_a = 8'h00;
    initial unit_out_b = 8'h00;

    always @(posedge alu_clk_a) begin
        unit_out_a   <= unit_eval(alu_op_a, alu_lhs_a, alu_rhs_a);
        pulses_a     <= pulses_a + 1;
        prev_pulse_t <= last_pulse_t;
        last_pulse_t <= $time;
    end

    always @(posedge alu_clk_b) begin
        unit_out_b <= unit_eval(alu_op_b, alu_lhs_b, alu_rhs_b);
        pulses_b   <= pulses_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request to A, wait for the accept edge, then count cycles until rsp_valid.
    task automatic send_a(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r,
                          output int lat, output int strobe_at);
        int guard = 0;
        req_valid_a = 1'b1; req_op_a = op; req_lhs_a = l; req_rhs_a = r;
        while (!req_ready_a && guard < 20) begin @(posedge clk); #1; guard++; end
        if (guard >= 20) check("a_req_ready_timeout", req_ready_a, 1);
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        lat = 0; strobe_at = -1;
        while (!rsp_valid_a && lat < 20) begin
            if (alu_clk_a) strobe_at = lat;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic send_b(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r,
                          output int lat, output int strobe_at, output bit stable);
        int guard = 0;
        req_valid_b = 1'b1; req_op_b = op; req_lhs_b = l; req_rhs_b = r;
        while (!req_ready_b && guard < 20) begin @(posedge clk); #1; guard++; end
        if (guard >= 20) check("b_req_ready_timeout", req_ready_b, 1);
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        lat = 0; strobe_at = -1; stable = 1'b1;
        while (!rsp_valid_b && lat < 20) begin
            if (alu_clk_b) strobe_at = lat;
            if ({alu_op_b, alu_lhs_b, alu_rhs_b} !== {op, l, r}) stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume_a();
        rsp_ready_a = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a = 1'b0;
        check("a_rsp_consumed", rsp_valid_a, 0);
    endtask

    task automatic consume_b();
        rsp_ready_b = 1'b1;
        @(posedge clk); #1;
        rsp_ready_b = 1'b0;
    endtask

    initial begin
        int  lat, sat, p0, n_got, acc_in_resp;
        bit  stable, acc, saw_valid;
        logic [7:0] got0, got1, exp_b;

        reset = 1'b1;
        req_valid_a = 1'b1; req_op_a = ALU_AND; req_lhs_a = 8'hFF; req_rhs_a = 8'hFF; rsp_ready_a = 1'b0;
        req_valid_b = 1'b0; req_op_b = 4'h0;   req_lhs_b = 8'h00; req_rhs_b = 8'h00; rsp_ready_b = 1'b0;

        // Reset state, with a request held during reset that must not be taken.
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_ops", {alu_op_a, alu_lhs_a, alu_rhs_a}, 20'h0);
        check("rst_rsp", {rsp_valid_a, rsp_zero_a, rsp_neg_a, alu_clk_a}, 4'b0100);
        check("rst_rsp_data", rsp_data_a, 8'h00);
        req_valid_a = 1'b0;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready_a, 1);
        check("post_rst_no_accept", {alu_op_a, alu_lhs_a}, 12'h0);
        check("post_rst_no_pulse", pulses_a, 0);

        // AND: latency, single pulse, data and flags.
        p0 = pulses_a;
        send_a(ALU_AND, 8'hF0, 8'h3C, lat, sat);
        check("and_latency", lat, 3);
        check("and_strobe_cycle", sat, 1);
        check("and_pulses", pulses_a - p0, 1);
        check("and_data", rsp_data_a, 8'h30);
        check("and_flags", {rsp_zero_a, rsp_neg_a}, 2'b00);
        consume_a();

        // NOR to zero.
        send_a(ALU_NOR, 8'hFF, 8'h00, lat, sat);
        check("nor_data", rsp_data_a, 8'h00);
        check("nor_flags", {rsp_zero_a, rsp_neg_a}, 2'b10);
        consume_a();

        // XOR with negative result, then 5 cycles of backpressure with a competing request.
        p0 = pulses_a;
        send_a(ALU_XOR, 8'h80, 8'h01, lat, sat);
        check("xor_data", rsp_data_a, 8'h81);
        check("xor_flags", {rsp_zero_a, rsp_neg_a}, 2'b01);
        req_valid_a = 1'b1; req_op_a = ALU_ONES; req_lhs_a = 8'h11; req_rhs_a = 8'h22;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold", {rsp_valid_a, req_ready_a, rsp_zero_a, rsp_neg_a, rsp_data_a}, {4'b1001, 8'h81});
            check("bp_ops", {alu_op_a, alu_lhs_a, alu_rhs_a}, {ALU_XOR, 8'h80, 8'h01});
        end
        check("bp_pulses", pulses_a - p0, 1);
        req_valid_a = 1'b0;
        consume_a();

        // Back-to-back with rsp_ready held high.
        rsp_ready_a = 1'b1;
        req_valid_a = 1'b1; req_op_a = ALU_OR; req_lhs_a = 8'h0F; req_rhs_a = 8'h30;
        @(posedge clk); #1;
        req_op_a = ALU_XNOR; req_lhs_a = 8'hAA; req_rhs_a = 8'h0F;
        n_got = 0; acc_in_resp = 0; got0 = 8'h00; got1 = 8'h00;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid_a) begin
                if (n_got == 0) got0 = rsp_data_a;
                if (n_got == 1) got1 = rsp_data_a;
                n_got++;
            end
            acc = req_valid_a && req_ready_a;
            if (acc && rsp_valid_a) acc_in_resp++;
            @(posedge clk); #1;
            if (acc) req_valid_a = 1'b0;
        end
        rsp_ready_a = 1'b0;
        check("b2b_count", n_got, 2);
        check("b2b_first", got0, 8'h3F);
        check("b2b_second", got1, 8'h5A);
        check("b2b_accept_in_resp", acc_in_resp, 1);
        check("b2b_pulse_spacing", int'((last_pulse_t - prev_pulse_t) / 10), 4);

        // Reset while alu_clk is high.
        req_valid_a = 1'b1; req_op_a = ALU_OR; req_lhs_a = 8'h11; req_rhs_a = 8'h22;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(posedge clk); #1;
        check("strobe_high", alu_clk_a, 1);
        p0 = pulses_a;
        #2 reset = 1'b1;
        #1;
        check("rst_strobe_drop", alu_clk_a, 0);
        check("rst_mid_ops", {alu_op_a, alu_lhs_a, alu_rhs_a}, 20'h0);
        check("rst_mid_rsp", {rsp_valid_a, rsp_zero_a, rsp_neg_a, rsp_data_a}, {3'b010, 8'h00});
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (rsp_valid_a) saw_valid = 1'b1; end
        check("rst_no_response", saw_valid, 0);
        check("rst_no_pulse", pulses_a - p0, 0);
        send_a(ALU_LHS, 8'h5C, 8'h00, lat, sat);
        check("rst_recover_latency", lat, 3);
        check("rst_recover_data", rsp_data_a, 8'h5C);
        consume_a();

        // SETTLE_CYCLES = 3: all 16 opcodes on 0xA5 / 0x3C.
        for (int op = 0; op < 16; op++) begin
            p0 = pulses_b;
            exp_b = ref_logic(4'(op), 8'hA5, 8'h3C);
            send_b(4'(op), 8'hA5, 8'h3C, lat, sat, stable);
            check($sformatf("s3_op%0h_latency", op), lat, 5);
            check($sformatf("s3_op%0h_strobe_cycle", op), sat, 3);
            check($sformatf("s3_op%0h_stable", op), stable, 1);
            check($sformatf("s3_op%0h_pulses", op), pulses_b - p0, 1);
            check($sformatf("s3_op%0h_data", op), rsp_data_b, exp_b);
            check($sformatf("s3_op%0h_zero", op), rsp_zero_b, (exp_b == 8'h00));
            consume_b();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
